// File: rtl/audio_conditioner.sv
// audio_conditioner: one-pole low-pass, optional DC blocker, saturator, frame hold register.
// Latency: in_valid at edge N -> sat/clipped at edge N+1 -> OUT at the next i2s_sampled edge (min 3 edges).
// Backpressure: none; one sample per cycle is always accepted, OUT holds between frame pulses.
//
// Ports:
//   CLK          system clock (24 MHz)
//   RST          synchronous active-high reset, priority over everything
//   IN[15:0]     signed mixer sample, taken when in_valid = 1
//   in_valid     sample strobe, may be high on consecutive cycles
//   i2s_sampled  frame pulse from the I2S stage, latches sat into OUT
//   OUT[15:0]    signed held sample for the I2S stage
//   clipped      one-cycle pulse when the saturator clamps
//
// Optional feature: define AUDIO_DCBLOCK_EN to insert the DC-blocking high-pass
// (uses DC_SHIFT). Without it hp = lp, clipped is tied low, latency is unchanged.
module audio_conditioner #(
  parameter int LP_SHIFT = 2,
  parameter int DC_SHIFT = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IN,
  input  logic        in_valid,
  input  logic        i2s_sampled,
  output logic [15:0] OUT,
  output logic        clipped
);

  // Elaboration-time parameter range guards.
  if (LP_SHIFT < 0 || LP_SHIFT > 8) begin : g_lp_range
    $error("audio_conditioner: LP_SHIFT must be 0..8");
  end
  if (DC_SHIFT < 4 || DC_SHIFT > 14) begin : g_dc_range
    $error("audio_conditioner: DC_SHIFT must be 4..14");
  end

  localparam int LPW = 16 + LP_SHIFT;

  logic signed [15:0]    in_sd;
  logic signed [LPW-1:0] lp_acc;
  logic signed [LPW-1:0] lp_next;
  logic signed [15:0]    lp;
  logic                  lp_upd;   // lp_acc changed at the previous edge
  logic signed [15:0]    sat;
  logic signed [15:0]    sat_next;

  assign in_sd = IN;
  // Accumulator holds y scaled by 2^k; the top 16 bits are the filter output.
  assign lp      = 16'(lp_acc >>> LP_SHIFT);
  assign lp_next = lp_acc + LPW'(in_sd) - LPW'(lp);

`ifdef AUDIO_DCBLOCK_EN
  localparam int DCW = 16 + DC_SHIFT;

  logic signed [DCW-1:0] dc_acc;
  logic signed [DCW-1:0] dc_next;
  logic signed [15:0]    dc;
  logic signed [16:0]    hp;
  logic                  clamp;

  assign dc      = 16'(dc_acc >>> DC_SHIFT);
  assign dc_next = dc_acc + DCW'(lp) - DCW'(dc);
  assign hp      = 17'(lp) - 17'(dc);

  // Overflow out of 16 bits shows as disagreement of the top two bits of hp.
  always_comb begin
    sat_next = hp[15:0];
    clamp    = 1'b0;
    if (hp[16:15] == 2'b01) begin
      sat_next = 16'sh7fff;
      clamp    = 1'b1;
    end else if (hp[16:15] == 2'b10) begin
      sat_next = 16'sh8000;
      clamp    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dc_acc  <= '0;
      clipped <= 1'b0;
    end else begin
      clipped <= lp_upd & clamp;
      if (lp_upd) dc_acc <= dc_next;
    end
  end
`else
  // Without the DC stage lp always fits in 16 bits, so no clamping is possible.
  assign sat_next = lp;
  assign clipped  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      lp_acc <= '0;
      lp_upd <= 1'b0;
      sat    <= '0;
      OUT    <= '0;
    end else begin
      lp_upd <= in_valid;
      if (in_valid)    lp_acc <= lp_next;
      if (lp_upd)      sat    <= sat_next;
      // Takes the pre-edge sat: a sat update at this same edge waits a frame.
      if (i2s_sampled) OUT    <= sat;
    end
  end

endmodule
